note_frame_controller: RTL
==========================

NOTE_FRAME_CONTROLLER -- requirements
Module: note_frame_controller

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-003 SHALL have ports pb_valid / pb_note / pb_on, inputs, 1/6/1, playback requester event: note index, 1=set, 0=clear.
REQ-004 SHALL have port pb_ready, output, 1, playback event accepted this cycle when pb_valid & pb_ready.
REQ-005 SHALL have ports key_valid / key_note / key_on, inputs, 1/6/1, key-input requester event, same encoding.
REQ-006 SHALL have port key_ready, output, 1, key event accepted this cycle when key_valid & key_ready.
REQ-007 SHALL have port clear_all, input, 1, clears every note in the shadow vector.
REQ-008 SHALL have port active, output, 48, current shadow note vector.
REQ-009 SHALL have port frame_start, output, 1, one-cycle pulse on each frame-buffer latch.
REQ-010 SHALL have ports note_serial_sync / note_serial_data, outputs, 1/1, serial link lines, registered.

Function
REQ-011 SHALL run free 7-bit divider div and 6-bit slot counter; slot advances by 1 (wrapping 63->0) when div==0; 128 clocks per slot, 64 slots per frame.
REQ-012 SHALL, on each div==0 cycle, set note_serial_sync=1 iff slot==63, else 0.
REQ-013 SHALL, on each div==0 cycle, drive note_serial_data=frame_buf[slot] for slot<48, and 0 for slots 48..63.
REQ-014 SHALL hold both serial outputs constant between div==0 cycles.
REQ-015 SHALL copy the registered shadow vector into frame_buf on the div==0 && slot==63 cycle; frame_start pulses high that same cycle.
REQ-016 SHALL therefore keep frame_buf constant for all 48 data slots of a frame; updates to the shadow vector mid-frame appear in the next frame.
REQ-017 SHALL arbitrate events round-robin: with one valid requester, grant it; with both valid, grant the requester not granted last.
REQ-018 SHALL drive ready combinationally from the valid inputs and arbitration state; at most one ready high per cycle.
REQ-019 SHALL assert neither ready while clear_all is high; clear_all zeroes the shadow vector next cycle.
REQ-020 SHALL, on an accepted event, set (on=1) or clear (on=0) shadow bit note on the next cycle; active reflects this one cycle after acceptance.
REQ-021 SHALL accept an event with note>=48 normally (handshake completes) but leave the shadow vector unchanged.
REQ-022 SHALL update last-grant state only on an accepted transfer; a requester holding valid low is not penalised.
REQ-023 SHALL treat set of an already-set bit, or clear of an already-clear bit, as a no-op.

Reset
REQ-024 SHALL, while rst is high at a clock edge, clear div, slot, shadow, frame_buf, note_serial_sync, note_serial_data and frame_start to 0, and set last-grant so playback wins the first tie.
REQ-025 SHALL drive pb_ready=key_ready=0 while rst is high.
REQ-026 SHALL, when rst is asserted mid-frame, abandon the frame; after release the first div==0 cycle emits slot 0 data from the cleared frame_buf.

Structure
REQ-027 SHALL place NUM_NOTES=48, NUM_SLOTS=64, SLOT_CLOCKS=128, the 6-bit note-index type and the SYNC_SLOT=63 constant in shared package note_link_pkg.
REQ-028 SHALL implement the two-requester round-robin logic as sub-module note_rr_arbiter; the divider, counters, shadow and frame buffer stay in the top.

Verification
REQ-029 Bench SHALL check: after reset, shadow=0, no events -> data 0 in every slot, sync high only for slot 63, period 8192 clocks, frame_start every 8192 clocks.
REQ-030 Bench SHALL check: pb event note=5 on=1 mid-frame -> active[5]=1 next cycle, serial slot 5 still 0 this frame and 1 next frame.
REQ-031 Bench SHALL check: pb and key valid together for 4 cycles (notes 1 and 2) -> grants alternate pb,key,pb,key from reset; both bits set.
REQ-032 Bench SHALL check: key event note=50 on=1 -> key_ready=1, handshake completes, active unchanged.
REQ-033 Bench SHALL check: clear_all with pb_valid high and active=all ones -> pb_ready=0 that cycle, active=0 next cycle, event accepted the following cycle.
REQ-034 Bench SHALL check: rst pulsed at slot 20 -> outputs 0, counters restart, first sync 63*128 clocks later at the slot-63 boundary.

Source files
------------

// File: rtl/note_link_pkg.sv
// Shared constants and types for the note frame link.
// Contents: note/slot/clock counts, derived counter widths, the note-index
// type, the sync slot number, the requester identifier and a range helper.
package note_link_pkg;

    localparam int NUM_NOTES   = 48;
    localparam int NUM_SLOTS   = 64;
    localparam int SLOT_CLOCKS = 128;

    localparam int DIV_W  = $clog2(SLOT_CLOCKS);
    localparam int SLOT_W = $clog2(NUM_SLOTS);

    typedef logic [5:0] note_idx_t;

    localparam note_idx_t SYNC_SLOT = 6'd63;

    // Identifies which requester won the most recent accepted transfer.
    typedef enum logic {
        REQ_PB  = 1'b0,
        REQ_KEY = 1'b1
    } requester_e;

    // True when an index addresses a real note (also a data-carrying slot).
    function automatic logic note_in_range(input note_idx_t idx);
        return (idx < note_idx_t'(NUM_NOTES));
    endfunction

endpackage

// File: rtl/note_rr_arbiter.sv
// Two-requester round-robin arbiter (playback vs key input).
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   block            - forces both grants low (reset / clear_all)
//   pb_valid         - playback requester has an event
//   key_valid        - key requester has an event
//   pb_grant         - playback event accepted this cycle (combinational)
//   key_grant        - key event accepted this cycle (combinational)
module note_rr_arbiter
    import note_link_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic block,
    input  logic pb_valid,
    input  logic key_valid,
    output logic pb_grant,
    output logic key_grant
);

    requester_e last_q;
    requester_e last_d;

    // Grant decision: a lone requester always wins; a tie goes to whoever
    // did not win the previous accepted transfer.
    always_comb begin
        pb_grant  = 1'b0;
        key_grant = 1'b0;
        if (block) begin
            pb_grant  = 1'b0;
            key_grant = 1'b0;
        end else if (pb_valid && key_valid) begin
            if (last_q == REQ_KEY) begin
                pb_grant = 1'b1;
            end else begin
                key_grant = 1'b1;
            end
        end else begin
            pb_grant  = pb_valid;
            key_grant = key_valid;
        end
    end

    // History moves only on an actual transfer, so an idle requester keeps
    // its turn.
    always_comb begin
        last_d = last_q;
        if (pb_grant) begin
            last_d = REQ_PB;
        end else if (key_grant) begin
            last_d = REQ_KEY;
        end else begin
            last_d = last_q;
        end
    end

    // History register; reset pretends key won last so playback wins the
    // first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= REQ_KEY;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/note_frame_controller.sv
// Note frame controller: keeps a 48-note shadow vector updated by two
// arbitrated event requesters and streams a frozen per-frame copy of it on
// a two-wire serial link (one bit per 128-clock slot, 64 slots per frame,
// sync marking slot 63).
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   pb_valid/pb_note/pb_on        - playback event (note index, 1=set 0=clear)
//   pb_ready                      - playback event accepted this cycle
//   key_valid/key_note/key_on     - key-input event, same encoding
//   key_ready                     - key event accepted this cycle
//   clear_all                     - zero the whole shadow vector
//   active                        - current shadow vector
//   frame_start                   - one-cycle pulse when the frame buffer latches
//   note_serial_sync/_data        - registered serial link lines
module note_frame_controller
    import note_link_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pb_valid,
    input  logic [5:0]           pb_note,
    input  logic                 pb_on,
    output logic                 pb_ready,
    input  logic                 key_valid,
    input  logic [5:0]           key_note,
    input  logic                 key_on,
    output logic                 key_ready,
    input  logic                 clear_all,
    output logic [NUM_NOTES-1:0] active,
    output logic                 frame_start,
    output logic                 note_serial_sync,
    output logic                 note_serial_data
);

    logic [DIV_W-1:0]     div_q,         div_d;
    logic [SLOT_W-1:0]    slot_q,        slot_d;
    logic [NUM_NOTES-1:0] shadow_q,      shadow_d;
    logic [NUM_NOTES-1:0] frame_buf_q,   frame_buf_d;
    logic                 sync_q,        sync_d;
    logic                 data_q,        data_d;
    logic                 frame_start_q, frame_start_d;

    logic      pb_grant;
    logic      key_grant;
    logic      evt_accept;
    note_idx_t evt_note;
    logic      evt_on;

    note_rr_arbiter u_arb (
        .clk       (clk),
        .rst       (rst),
        .block     (rst | clear_all),
        .pb_valid  (pb_valid),
        .key_valid (key_valid),
        .pb_grant  (pb_grant),
        .key_grant (key_grant)
    );

    // Slot timing and serial line drive. Everything happens on the div==0
    // cycle; the lines are held in between. The slot-63 cycle also freezes
    // the shadow vector into the frame buffer for the coming frame.
    always_comb begin
        div_d         = div_q + DIV_W'(1);
        slot_d        = slot_q;
        frame_buf_d   = frame_buf_q;
        sync_d        = sync_q;
        data_d        = data_q;
        frame_start_d = 1'b0;
        if (div_q == DIV_W'(0)) begin
            slot_d = slot_q + SLOT_W'(1);
            sync_d = (slot_q == SYNC_SLOT);
            if (note_in_range(slot_q)) begin
                data_d = frame_buf_q[slot_q];
            end else begin
                data_d = 1'b0;
            end
            if (slot_q == SYNC_SLOT) begin
                frame_buf_d   = shadow_q;
                frame_start_d = 1'b1;
            end else begin
                frame_start_d = 1'b0;
            end
        end else begin
            slot_d = slot_q;
        end
    end

    // Select the winning event (at most one grant is ever high).
    always_comb begin
        evt_accept = pb_grant | key_grant;
        evt_note   = 6'd0;
        evt_on     = 1'b0;
        if (pb_grant) begin
            evt_note = pb_note;
            evt_on   = pb_on;
        end else if (key_grant) begin
            evt_note = key_note;
            evt_on   = key_on;
        end else begin
            evt_note = 6'd0;
            evt_on   = 1'b0;
        end
    end

    // Shadow update. Out-of-range notes complete the handshake but touch
    // nothing; writing the current value back makes set/clear idempotent.
    always_comb begin
        shadow_d = shadow_q;
        if (clear_all) begin
            shadow_d = {NUM_NOTES{1'b0}};
        end else if (evt_accept && note_in_range(evt_note)) begin
            shadow_d[evt_note] = evt_on;
        end else begin
            shadow_d = shadow_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q         <= {DIV_W{1'b0}};
            slot_q        <= {SLOT_W{1'b0}};
            shadow_q      <= {NUM_NOTES{1'b0}};
            frame_buf_q   <= {NUM_NOTES{1'b0}};
            sync_q        <= 1'b0;
            data_q        <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            slot_q        <= slot_d;
            shadow_q      <= shadow_d;
            frame_buf_q   <= frame_buf_d;
            sync_q        <= sync_d;
            data_q        <= data_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pb_ready         = pb_grant;
    assign key_ready        = key_grant;
    assign active           = shadow_q;
    assign frame_start      = frame_start_q;
    assign note_serial_sync = sync_q;
    assign note_serial_data = data_q;

endmodule
